// File: rtl/vend_pkg.sv
// Shared types and sizes for the vending scheduler: FSM states, latched request payload.
package vend_pkg;

  localparam int unsigned ITEM_W  = 2;
  localparam int unsigned N_ITEMS = 4;
  localparam int unsigned STOCK_W = 4;
  localparam int unsigned QTY_W   = 4;
  localparam int unsigned SOLD_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DISPENSE,
    CHANGE,
    REFUND,
    FAULT
  } state_t;

  typedef struct packed {
    logic [ITEM_W-1:0] item;
    logic              half;
  } vend_req_t;

  function automatic logic [N_ITEMS-1:0] item_onehot(input logic [ITEM_W-1:0] item);
    return N_ITEMS'(1) << item;
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters: saturating refill merged with same-cycle dispense decrement.
module vend_stock
  import vend_pkg::*;
#(
  parameter int unsigned STOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              refill,
  input  logic [ITEM_W-1:0] refill_item,
  input  logic [QTY_W-1:0]  refill_qty,
  input  logic              dec,
  input  logic [ITEM_W-1:0] dec_item,
  output logic [N_ITEMS-1:0] empty
);

  localparam int unsigned SUM_W = STOCK_W + 1;

  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];

  // Add first, then take the dispensed unit, then clamp, so a coincident refill never loses a unit.
  function automatic logic [STOCK_W-1:0] next_stock(
    input logic [STOCK_W-1:0] cur,
    input logic               add_en,
    input logic [QTY_W-1:0]   qty,
    input logic               sub_en
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cur) + (add_en ? SUM_W'(qty) : SUM_W'(0));
    if (sub_en && (sum != SUM_W'(0))) sum = sum - SUM_W'(1);
    if (sum > SUM_W'(STOCK_MAX)) sum = SUM_W'(STOCK_MAX);
    return sum[STOCK_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      stock_d[i] = next_stock(stock_q[i],
                              refill && (refill_item == ITEM_W'(i)),
                              refill_qty,
                              dec && (dec_item == ITEM_W'(i)));
      empty[i]   = (stock_q[i] == STOCK_W'(0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

endmodule

// File: rtl/vend_sched.sv
// Vending scheduler: accepts paid requests, checks stock, drives the shared motor and change return.
// Optional dispense watchdog / FAULT state enabled by defining VEND_SCHED_TIMEOUT_EN.
module vend_sched
  import vend_pkg::*;
#(
  parameter int unsigned STOCK_MAX     = 15,
  parameter int unsigned MOTOR_TIMEOUT = 1000,
  parameter int unsigned HALF_PULSE    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vend_req,
  input  logic [ITEM_W-1:0]  vend_item,
  input  logic               change_half,
  input  logic               motor_done,
  input  logic               refill,
  input  logic [ITEM_W-1:0]  refill_item,
  input  logic [QTY_W-1:0]   refill_qty,
  input  logic               fault_clr,
  output logic               vend_ack,
  output logic               vend_busy,
  output logic [N_ITEMS-1:0] motor_on,
  output logic               half_out,
  output logic               refund,
  output logic [SOLD_W-1:0]  sold_cnt,
  output logic [N_ITEMS-1:0] empty,
  output logic               fault
);

  localparam int unsigned CNT_MAX = (MOTOR_TIMEOUT > HALF_PULSE) ? MOTOR_TIMEOUT : HALF_PULSE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  vend_req_t        req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dispense_done;

  vend_stock #(
    .STOCK_MAX (STOCK_MAX)
  ) u_stock (
    .clk         (clk),
    .rst_n       (rst_n),
    .refill      (refill),
    .refill_item (refill_item),
    .refill_qty  (refill_qty),
    .dec         (dispense_done),
    .dec_item    (req_q.item),
    .empty       (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; cnt_q counts cycles spent in the current state (watchdog and change pulse).
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cnt_d         = cnt_q + CNT_W'(1);
    dispense_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (vend_req) begin
          req_d.item = vend_item;
          req_d.half = change_half;
          state_d    = CHECK;
        end
      end
      CHECK:    state_d = empty[req_q.item] ? REFUND : DISPENSE;
      DISPENSE: begin
        if (motor_done) begin
          dispense_done = 1'b1;
          state_d       = req_q.half ? CHANGE : IDLE;
        end
`ifdef VEND_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MOTOR_TIMEOUT - 1)) begin
          state_d = FAULT;
        end
`endif
      end
      CHANGE: begin
        if (cnt_q == CNT_W'(HALF_PULSE - 1)) state_d = IDLE;
      end
      REFUND: state_d = IDLE;
      FAULT: begin
`ifdef VEND_SCHED_TIMEOUT_EN
        if (fault_clr) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vend_ack  <= 1'b0;
      vend_busy <= 1'b0;
      motor_on  <= '0;
      half_out  <= 1'b0;
      refund    <= 1'b0;
      sold_cnt  <= '0;
    end else begin
      vend_ack  <= (state_q == IDLE) && vend_req;
      vend_busy <= (state_d != IDLE);
      motor_on  <= (state_d == DISPENSE) ? item_onehot(req_q.item) : '0;
      half_out  <= (state_d == CHANGE);
      refund    <= (state_d == REFUND);
      if (dispense_done) sold_cnt <= sold_cnt + SOLD_W'(1);
    end
  end

`ifdef VEND_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault <= 1'b0;
    else        fault <= (state_d == FAULT);
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_vend_sched.sv
// Scoreboarded bench for vend_sched: a stock/sales model predicts refund vs dispense per request.
module tb_vend_sched;

  localparam int STOCK_MAX     = 15;
  localparam int MOTOR_TIMEOUT = 10;
  localparam int HALF_PULSE    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vend_req = 1'b0;
  logic [1:0] vend_item = 2'd0;
  logic       change_half = 1'b0;
  logic       motor_done = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_item = 2'd0;
  logic [3:0] refill_qty = 4'd0;
  logic       fault_clr = 1'b0;
  logic       vend_ack, vend_busy, half_out, refund, fault;
  logic [3:0] motor_on, empty;
  logic [7:0] sold_cnt;

  vend_sched #(
    .STOCK_MAX     (STOCK_MAX),
    .MOTOR_TIMEOUT (MOTOR_TIMEOUT),
    .HALF_PULSE    (HALF_PULSE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vend_req    (vend_req),
    .vend_item   (vend_item),
    .change_half (change_half),
    .motor_done  (motor_done),
    .refill      (refill),
    .refill_item (refill_item),
    .refill_qty  (refill_qty),
    .fault_clr   (fault_clr),
    .vend_ack    (vend_ack),
    .vend_busy   (vend_busy),
    .motor_on    (motor_on),
    .half_out    (half_out),
    .refund      (refund),
    .sold_cnt    (sold_cnt),
    .empty       (empty),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit refund;
    int item;
    bit half;
  } exp_t;

  exp_t exp_q[$];
  int   model_stock[4];
  int   model_sold;
  int   checks;
  int   failures;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (model_stock[i] == 0);
    return e;
  endfunction

  task automatic do_refill(input int item, input int qty);
    int s;
    refill = 1'b1; refill_item = 2'(item); refill_qty = 4'(qty);
    tick();
    refill = 1'b0;
    s = model_stock[item] + qty;
    model_stock[item] = (s > STOCK_MAX) ? STOCK_MAX : s;
    checks++;
    if (empty !== model_empty()) begin
      failures++;
      $display("FAIL refill_empty item=%0d got=%b exp=%b", item, empty, model_empty());
    end
  endtask

  // One full vend transaction; the scoreboard entry decides whether a refund or a dispense is due.
  task automatic do_vend(input int item, input bit half, input int hold, input bit spurious,
                         input bit co_refill, input int co_qty);
    exp_t e;
    int   n, s;
    e.refund = (model_stock[item] == 0);
    e.item   = item;
    e.half   = half;
    exp_q.push_back(e);
    vend_req = 1'b1; vend_item = 2'(item); change_half = half;
    tick();
    vend_req = 1'b0; change_half = 1'b0;
    checks++;
    if (vend_ack !== 1'b1) begin
      failures++;
      $display("FAIL vend_ack item=%0d got=%b exp=1", item, vend_ack);
    end
    tick();
    e = exp_q.pop_front();
    if (e.refund) begin
      checks++;
      if (refund !== 1'b1 || motor_on !== 4'b0 || vend_ack !== 1'b0) begin
        failures++;
        $display("FAIL refund_pulse item=%0d got refund=%b motor_on=%b ack=%b exp refund=1 motor_on=0000 ack=0",
                 e.item, refund, motor_on, vend_ack);
      end
      tick();
      checks++;
      if (refund !== 1'b0 || vend_busy !== 1'b0 || motor_on !== 4'b0 || sold_cnt !== 8'(model_sold)) begin
        failures++;
        $display("FAIL refund_end item=%0d got refund=%b busy=%b motor_on=%b sold=%0d exp 0/0/0000/%0d",
                 e.item, refund, vend_busy, motor_on, sold_cnt, model_sold);
      end
    end else begin
      for (int k = 0; k < hold; k++) begin
        checks++;
        if (motor_on !== 4'(1 << e.item) || half_out !== 1'b0 || fault !== 1'b0) begin
          failures++;
          $display("FAIL motor_hold item=%0d cyc=%0d got motor_on=%b half=%b fault=%b exp motor_on=%b half=0 fault=0",
                   e.item, k, motor_on, half_out, fault, 4'(1 << e.item));
        end
        if (spurious && k == 1) begin
          checks++;
          if (vend_ack !== 1'b0) begin
            failures++;
            $display("FAIL busy_req_ignored got ack=%b exp=0", vend_ack);
          end
        end
        if (k < hold - 1) begin
          vend_req  = spurious && (k == 0);
          vend_item = 2'(e.item ^ 1);
          tick();
        end
      end
      vend_req   = 1'b0;
      motor_done = 1'b1;
      if (co_refill) begin
        refill = 1'b1; refill_item = 2'(item); refill_qty = 4'(co_qty);
      end
      tick();
      motor_done = 1'b0; refill = 1'b0;
      s = model_stock[item] - 1 + (co_refill ? co_qty : 0);
      model_stock[item] = (s > STOCK_MAX) ? STOCK_MAX : s;
      model_sold = (model_sold + 1) % 256;
      checks++;
      if (motor_on !== 4'b0 || sold_cnt !== 8'(model_sold) || empty !== model_empty()) begin
        failures++;
        $display("FAIL motor_done item=%0d got motor_on=%b sold=%0d empty=%b exp 0000/%0d/%b",
                 e.item, motor_on, sold_cnt, empty, model_sold, model_empty());
      end
      if (e.half) begin
        n = 0;
        while (half_out === 1'b1 && n < 20) begin
          n++;
          tick();
        end
        checks++;
        if (n != HALF_PULSE) begin
          failures++;
          $display("FAIL half_width got=%0d exp=%0d", n, HALF_PULSE);
        end
      end else begin
        checks++;
        if (half_out !== 1'b0) begin
          failures++;
          $display("FAIL no_change got half=%b exp=0", half_out);
        end
      end
      checks++;
      if (vend_busy !== 1'b0) begin
        failures++;
        $display("FAIL back_to_idle got busy=%b exp=0", vend_busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (vend_ack !== 1'b0 || vend_busy !== 1'b0 || motor_on !== 4'b0 || half_out !== 1'b0 ||
        refund !== 1'b0 || sold_cnt !== 8'd0 || empty !== 4'b1111 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got ack=%b busy=%b motor=%b half=%b refund=%b sold=%0d empty=%b fault=%b exp all 0, empty=1111",
               vend_ack, vend_busy, motor_on, half_out, refund, sold_cnt, empty, fault);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_refund_empty();
    do_vend(1, 1'b0, 1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_basic_vend();
    do_refill(2, 3);
    do_vend(2, 1'b0, 5, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    do_vend(2, 1'b0, 2, 1'b0, 1'b0, 0);
    do_vend(2, 1'b0, 1, 1'b0, 1'b0, 0);
    do_vend(2, 1'b0, 1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_change();
    do_refill(3, 2);
    do_vend(3, 1'b1, 3, 1'b0, 1'b0, 0);
  endtask

  task automatic test_ignore_done();
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    tick();
    checks++;
    if (sold_cnt !== 8'(model_sold) || motor_on !== 4'b0 || vend_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_done_ignored got sold=%0d motor=%b busy=%b exp %0d/0000/0",
               sold_cnt, motor_on, vend_busy, model_sold);
    end
  endtask

  task automatic test_saturation();
    do_refill(0, 14);
    do_refill(0, 5);
    do_vend(0, 1'b0, 1, 1'b0, 1'b1, 1);
    for (int i = 0; i < 16; i++) do_vend(0, 1'b0, 1, 1'b0, 1'b0, 0);
  endtask

`ifdef VEND_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_refill(3, 1);
    vend_req = 1'b1; vend_item = 2'd3; change_half = 1'b0;
    tick();
    vend_req = 1'b0;
    tick();
    for (int k = 0; k < MOTOR_TIMEOUT; k++) begin
      checks++;
      if (motor_on !== 4'b1000 || fault !== 1'b0) begin
        failures++;
        $display("FAIL wd_dispense cyc=%0d got motor=%b fault=%b exp 1000/0", k, motor_on, fault);
      end
      tick();
    end
    checks++;
    if (fault !== 1'b1 || motor_on !== 4'b0 || vend_busy !== 1'b1 || sold_cnt !== 8'(model_sold)) begin
      failures++;
      $display("FAIL wd_fault got fault=%b motor=%b busy=%b sold=%0d exp 1/0000/1/%0d",
               fault, motor_on, vend_busy, sold_cnt, model_sold);
    end
    vend_req = 1'b1; vend_item = 2'd3;
    tick();
    vend_req = 1'b0;
    checks++;
    if (vend_ack !== 1'b0 || fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_req_ignored got ack=%b fault=%b exp 0/1", vend_ack, fault);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || vend_busy !== 1'b0) begin
      failures++;
      $display("FAIL fault_clr got fault=%b busy=%b exp 0/0", fault, vend_busy);
    end
    do_vend(3, 1'b0, 1, 1'b0, 1'b0, 0);
  endtask
`else
  task automatic test_no_timeout();
    do_refill(3, 1);
    do_vend(3, 1'b0, 3 * MOTOR_TIMEOUT, 1'b0, 1'b0, 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || vend_busy !== 1'b0) begin
      failures++;
      $display("FAIL no_watchdog got fault=%b busy=%b exp 0/0", fault, vend_busy);
    end
  endtask
`endif

  task automatic test_reset_mid_dispense();
    do_refill(1, 2);
    vend_req = 1'b1; vend_item = 2'd1; change_half = 1'b1;
    tick();
    vend_req = 1'b0; change_half = 1'b0;
    repeat (3) tick();
    checks++;
    if (motor_on !== 4'b0010) begin
      failures++;
      $display("FAIL pre_reset_motor got=%b exp=0010", motor_on);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (motor_on !== 4'b0 || half_out !== 1'b0 || sold_cnt !== 8'd0 || empty !== 4'b1111 || vend_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got motor=%b half=%b sold=%0d empty=%b busy=%b exp 0000/0/0/1111/0",
               motor_on, half_out, sold_cnt, empty, vend_busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model_stock[i] = 0;
    model_sold = 0;
    exp_q.delete();
    tick();
    do_vend(1, 1'b0, 1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    model_sold = 0;
    for (int i = 0; i < 4; i++) model_stock[i] = 0;
    test_reset();
    test_refund_empty();
    test_basic_vend();
    test_back_to_back();
    test_change();
    test_ignore_done();
    test_saturation();
`ifdef VEND_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_dispense();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_sched.md
VEND_SCHED -- requirements
Module: vend_sched

Interface
REQ-001 Parameter STOCK_MAX, default 15, per-item stock saturation value (1..15).
REQ-002 Parameter MOTOR_TIMEOUT, default 1000, dispense watchdog limit in clk cycles.
REQ-003 Parameter HALF_PULSE, default 4, change-return pulse width in clk cycles (>=1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 vend_req  input  1  one-cycle pulse: customer has paid 2.5 rmb, vend requested.
REQ-007 vend_item  input  2  item index, valid with vend_req.
REQ-008 change_half  input  1  0.5 rmb change owed, valid with vend_req.
REQ-009 motor_done  input  1  one-cycle pulse from the shared dispense actuator: item dropped.
REQ-010 refill  input  1  one-cycle pulse: add refill_qty to stock of refill_item.
REQ-011 refill_item  input  2  item index, valid with refill.
REQ-012 refill_qty  input  4  units added, valid with refill.
REQ-013 fault_clr  input  1  one-cycle pulse clearing the FAULT state.
REQ-014 vend_ack  output  1  one-cycle pulse: request accepted.
REQ-015 vend_busy  output  1  high whenever the FSM is not IDLE.
REQ-016 motor_on  output  4  one-hot actuator enable, bit = item index.
REQ-017 half_out  output  1  change-return drive, HALF_PULSE cycles wide.
REQ-018 refund  output  1  one-cycle pulse: item empty, full credit returned.
REQ-019 sold_cnt  output  8  total successful vends.
REQ-020 empty  output  4  bit i high when stock of item i equals 0.
REQ-021 fault  output  1  high while in FAULT.

Function
REQ-022 FSM states SHALL be IDLE, CHECK, DISPENSE, CHANGE, REFUND, FAULT.
REQ-023 In IDLE, vend_req SHALL latch vend_item and change_half, move to CHECK next cycle, and pulse vend_ack in that same next cycle.
REQ-024 vend_req outside IDLE SHALL be ignored: no ack, no latch.
REQ-025 CHECK SHALL last one cycle: stock of latched item 0 -> REFUND, else -> DISPENSE.
REQ-026 REFUND SHALL assert refund for exactly one cycle, then return to IDLE; stock and sold_cnt unchanged.
REQ-027 DISPENSE SHALL hold motor_on[item] high, all other bits low, until motor_done is sampled high.
REQ-028 On motor_done in DISPENSE: motor_on drops next cycle, stock of item decrements by 1, sold_cnt increments by 1 (wraps 255->0), next state CHANGE if change_half latched, else IDLE.
REQ-029 motor_done outside DISPENSE SHALL be ignored.
REQ-030 CHANGE SHALL hold half_out high exactly HALF_PULSE cycles, then go to IDLE.
REQ-031 refill SHALL be accepted in every state; stock = min(stock + refill_qty, STOCK_MAX).
REQ-032 Refill and dispense decrement on the same item in the same cycle SHALL apply both: min(stock - 1 + refill_qty, STOCK_MAX).
REQ-033 empty SHALL be combinational from the stock registers.
REQ-034 Minimum vend latency: vend_req at cycle N -> motor_on at N+2.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, all outputs 0 except empty = 4'b1111, all stock = 0, sold_cnt = 0.
REQ-036 Reset during DISPENSE or CHANGE SHALL drop motor_on/half_out at once; the interrupted vend SHALL not be counted.

Configuration
REQ-037 Macro VEND_SCHED_TIMEOUT_EN defined: a watchdog counts DISPENSE cycles; reaching MOTOR_TIMEOUT without motor_done -> FAULT (motor_on = 0, fault = 1, stock and sold_cnt unchanged); fault_clr in FAULT -> IDLE next cycle.
REQ-038 Macro undefined: no watchdog, DISPENSE waits indefinitely, FAULT unreachable, fault tied 0, fault_clr ignored.

Structure
REQ-039 Package vend_pkg SHALL hold the state enum, ITEM_W = 2, N_ITEMS = 4, STOCK_W = 4.
REQ-040 Sub-module vend_stock SHALL hold the four stock counters with saturation, refill/decrement merge and empty flags.

Verification
REQ-041 Refill item 2 qty 3; vend_req item 2, change_half 0; motor_done after 5 cycles -> vend_ack at N+1, motor_on = 4'b0100 from N+2, stock = 2, sold_cnt = 1, back to IDLE.
REQ-042 vend_req item 1 after reset (stock 0) -> refund single pulse at N+2, sold_cnt = 0, motor_on never set.
REQ-043 Vend with change_half 1, HALF_PULSE = 4 -> half_out high exactly 4 cycles after motor_done.
REQ-044 Stock item 0 = 14, refill qty 5 -> stock = 15; refill coincident with motor_done on item 0 at stock 15, qty 1 -> stock = 15.
REQ-045 VEND_SCHED_TIMEOUT_EN, MOTOR_TIMEOUT = 10, no motor_done -> fault = 1 after 10 DISPENSE cycles; second vend_req ignored; fault_clr -> IDLE.
REQ-046 rst_n pulsed low mid-DISPENSE -> motor_on = 0 immediately, sold_cnt = 0, empty = 4'b1111.
